// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the matrix-multiply processing element.
// Module parameters default from the PE_* constants so a grid can be resized in one place.
package matmul_pkg;

   localparam int PE_DATA_WIDTH = 8;
   localparam int PE_BUS_WIDTH  = 32;
   localparam int PE_MAX_DIM    = PE_BUS_WIDTH / PE_DATA_WIDTH;
   localparam int DIM_W         = $clog2(PE_MAX_DIM) + 1;

   typedef logic [PE_DATA_WIDTH-1:0] elem_t;
   typedef logic [PE_BUS_WIDTH-1:0]  acc_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } pe_state_t;

endpackage

// File: rtl/matmul_mac.sv
// Combinational extend-multiply-accumulate with overflow flag; zero latency, no flow control.
// Signed mode checks two's-complement overflow, unsigned mode reports carry out of the accumulator.
module matmul_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                  i_signed,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [BUS_WIDTH-1:0]  i_acc,
   output logic [BUS_WIDTH-1:0]  o_sum,
   output logic                  o_ovf
);

   // One guard bit per operand lets a single signed multiplier serve both modes.
   localparam int PW = 2 * DATA_WIDTH + 2;

   logic signed [DATA_WIDTH:0] w_a_ext;
   logic signed [DATA_WIDTH:0] w_b_ext;
   logic signed [PW-1:0]       w_a_wide;
   logic signed [PW-1:0]       w_b_wide;
   logic signed [PW-1:0]       w_prod;
   logic [BUS_WIDTH-1:0]       w_prod_ext;
   logic                       w_carry;

   assign w_a_ext    = $signed({i_signed & i_a[DATA_WIDTH-1], i_a});
   assign w_b_ext    = $signed({i_signed & i_b[DATA_WIDTH-1], i_b});
   assign w_a_wide   = PW'(w_a_ext);
   assign w_b_wide   = PW'(w_b_ext);
   assign w_prod     = w_a_wide * w_b_wide;
   assign w_prod_ext = {{(BUS_WIDTH-PW){w_prod[PW-1]}}, w_prod};

   assign {w_carry, o_sum} = {1'b0, i_acc} + {1'b0, w_prod_ext};

   assign o_ovf = i_signed ? ((i_acc[BUS_WIDTH-1] == w_prod_ext[BUS_WIDTH-1]) &&
                              (o_sum[BUS_WIDTH-1] != i_acc[BUS_WIDTH-1]))
                           : w_carry;

endmodule

// File: rtl/matmul_pe.sv
// Systolic MAC cell: accumulates k beats onto a preload, forwards A/B/valid with 1-cycle latency.
// No backpressure; done_o pulses one cycle after the k-th beat, start_i restarts from any state.
module matmul_pe #(
   parameter int DATA_WIDTH = matmul_pkg::PE_DATA_WIDTH,
   parameter int BUS_WIDTH  = matmul_pkg::PE_BUS_WIDTH,
   parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
   parameter int DIM_W      = $clog2(MAX_DIM) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [DIM_W-1:0]      k_i,
   input  logic                  signed_i,
   input  logic                  bias_en_i,
   input  logic [BUS_WIDTH-1:0]  bias_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] a_o,
   output logic [DATA_WIDTH-1:0] b_o,
   output logic [BUS_WIDTH-1:0]  acc_o,
   output logic                  overflow_o,
   output logic                  done_o,
   output logic                  busy_o
);

   import matmul_pkg::*;

   pe_state_t             r_state;
   pe_state_t             w_state_nxt;
   logic                  w_accum;
   logic [DIM_W-1:0]      r_cnt;
   logic [DIM_W-1:0]      r_k;
   logic [DIM_W-1:0]      w_k_eff;
   logic [DIM_W-1:0]      w_cnt_inc;
   logic                  r_signed;
   logic [BUS_WIDTH-1:0]  r_acc;
   logic                  r_ovf;
   logic                  r_vld;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [BUS_WIDTH-1:0]  w_preload;
   logic [BUS_WIDTH-1:0]  w_mac_acc;
   logic                  w_mac_signed;
   logic [BUS_WIDTH-1:0]  w_sum;
   logic                  w_ovf;

   assign w_k_eff   = (k_i > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : k_i;
   assign w_cnt_inc = r_cnt + DIM_W'(1);
   assign w_preload = bias_en_i ? bias_i : '0;

   // A beat arriving with start_i accumulates on top of the fresh preload in the new mode.
   assign w_mac_acc    = start_i ? w_preload : r_acc;
   assign w_mac_signed = start_i ? signed_i  : r_signed;

   matmul_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUS_WIDTH  (BUS_WIDTH)
   ) u_mac (
      .i_signed (w_mac_signed),
      .i_a      (a_i),
      .i_b      (b_i),
      .i_acc    (w_mac_acc),
      .o_sum    (w_sum),
      .o_ovf    (w_ovf)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accum     = 1'b0;
      if (start_i) begin
         if (w_k_eff == '0) begin
            w_state_nxt = DONE;
         end else begin
            w_accum     = valid_i;
            w_state_nxt = (valid_i && w_k_eff == DIM_W'(1)) ? DONE : ACC;
         end
      end else begin
         case (r_state)
            ACC: begin
               if (valid_i) begin
                  w_accum = 1'b1;
                  if (w_cnt_inc == r_k) w_state_nxt = DONE;
               end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt    <= '0;
         r_k      <= '0;
         r_signed <= 1'b0;
         r_acc    <= '0;
         r_ovf    <= 1'b0;
      end else if (start_i) begin
         r_k      <= w_k_eff;
         r_signed <= signed_i;
         r_acc    <= w_accum ? w_sum : w_preload;
         r_ovf    <= w_accum & w_ovf;
         r_cnt    <= w_accum ? DIM_W'(1) : '0;
      end else if (w_accum) begin
         r_acc    <= w_sum;
         r_ovf    <= r_ovf | w_ovf;
         r_cnt    <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vld <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
      end else begin
         r_vld <= valid_i;
         if (valid_i) begin
            r_a <= a_i;
            r_b <= b_i;
         end
      end
   end

   assign valid_o    = r_vld;
   assign a_o        = r_a;
   assign b_o        = r_b;
   assign acc_o      = r_acc;
   assign overflow_o = r_ovf;
   assign done_o     = (r_state == DONE);
   assign busy_o     = (r_state == ACC);

endmodule
